// File: rtl/mine_placer.sv
// mine_placer: Wishbone write master that wipes the board memory and then
// scatters mine_count mines on LFSR-chosen cells, never on the first-click cell.
module mine_placer #(
    parameter int          BOARD_SIZE = 16,
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [7:0]                    mine_count,
    input  logic [$clog2(BOARD_SIZE)-1:0] safe_x,
    input  logic [$clog2(BOARD_SIZE)-1:0] safe_y,
    output logic                          busy,
    output logic                          done,
    output logic                          wb_cyc,
    output logic                          wb_stb,
    output logic                          wb_we,
    output logic [ADDR_W-1:0]             wb_adr,
    output logic [DATA_W-1:0]             wb_dat_w,
    input  logic                          wb_ack
);
    localparam int          CELLS     = BOARD_SIZE * BOARD_SIZE;
    localparam logic [7:0]  MAX_MINES = 8'(CELLS - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        PLACE,
        FIN
    } state_t;

    // More mines than non-safe cells could never terminate, so cap the request.
    function automatic logic [7:0] clamp_count(input logic [7:0] n);
        return (n > MAX_MINES) ? MAX_MINES : n;
    endfunction

    // Right-shifting Galois step; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    state_t              state, state_n;
    logic [15:0]         lfsr;
    logic [CELLS-1:0]    bitmap;
    logic [7:0]          mines, mines_n;
    logic [7:0]          placed, placed_n;
    logic [ADDR_W-1:0]   safe_adr, safe_adr_n;
    logic                busy_n, done_n;
    logic                cyc_n, stb_n, we_n;
    logic [ADDR_W-1:0]   adr_n;
    logic [DATA_W-1:0]   dat_n;
    logic [ADDR_W-1:0]   cand;
    logic                reject;
    logic                wr_done;

    assign cand    = lfsr[ADDR_W-1:0];
    assign reject  = (cand == safe_adr) || bitmap[cand];
    assign wr_done = wb_stb && wb_ack;

    // Free-running LFSR: stepping in every state ties the layout to player timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Placed-cell bitmap, updated only when a write is acknowledged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitmap <= '0;
        end else if (wr_done) begin
            if (state == CLEAR) begin
                bitmap[wb_adr] <= 1'b0;
            end else if (state == PLACE) begin
                bitmap[wb_adr] <= 1'b1;
            end
        end
    end

    // State, counters and all bus outputs are registered from the next-state logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mines    <= '0;
            placed   <= '0;
            safe_adr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_w <= '0;
        end else begin
            state    <= state_n;
            mines    <= mines_n;
            placed   <= placed_n;
            safe_adr <= safe_adr_n;
            busy     <= busy_n;
            done     <= done_n;
            wb_cyc   <= cyc_n;
            wb_stb   <= stb_n;
            wb_we    <= we_n;
            wb_adr   <= adr_n;
            wb_dat_w <= dat_n;
        end
    end

    // Next-state and bus sequencing: one write in flight, stb dropped after each ack.
    always_comb begin
        state_n    = state;
        mines_n    = mines;
        placed_n   = placed;
        safe_adr_n = safe_adr;
        busy_n     = busy;
        done_n     = 1'b0;
        cyc_n      = wb_cyc;
        stb_n      = wb_stb;
        we_n       = wb_we;
        adr_n      = wb_adr;
        dat_n      = wb_dat_w;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = CLEAR;
                    busy_n     = 1'b1;
                    mines_n    = clamp_count(mine_count);
                    safe_adr_n = {safe_y, safe_x};
                    placed_n   = '0;
                    adr_n      = '0;
                    dat_n      = '0;
                    cyc_n      = 1'b1;
                    stb_n      = 1'b1;
                    we_n       = 1'b1;
                end
            end

            CLEAR: begin
                if (wr_done) begin
                    cyc_n = 1'b0;
                    stb_n = 1'b0;
                    we_n  = 1'b0;
                    if (wb_adr == '1) begin
                        adr_n   = '0;
                        state_n = (mines != 8'd0) ? PLACE : FIN;
                    end else begin
                        adr_n = wb_adr + 1'b1;
                    end
                end else if (!wb_stb) begin
                    cyc_n = 1'b1;
                    stb_n = 1'b1;
                    we_n  = 1'b1;
                end
            end

            PLACE: begin
                if (wr_done) begin
                    cyc_n    = 1'b0;
                    stb_n    = 1'b0;
                    we_n     = 1'b0;
                    placed_n = placed + 8'd1;
                    if (placed_n == mines) begin
                        state_n = FIN;
                        adr_n   = '0;
                        dat_n   = '0;
                    end
                end else if (!wb_stb && !reject) begin
                    cyc_n = 1'b1;
                    stb_n = 1'b1;
                    we_n  = 1'b1;
                    adr_n = cand;
                    dat_n = DATA_W'(1);
                end
            end

            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: randomized scoreboard bench for mine_placer with a simple
// Wishbone slave (programmable ack delay, spurious acks while stb is low).
module tb_mine_placer;
    localparam int          BS     = 16;
    localparam int          NCELL  = BS * BS;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          K_CLR  = 0;
    localparam int          K_MINE = 1;
    localparam int          K_DONE = 2;

    typedef struct {
        int kind;
        int adr;
        int cnt;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mine_count = 8'd0;
    logic [3:0] safe_x = 4'd0;
    logic [3:0] safe_y = 4'd0;
    logic       busy, done;
    logic       wb_cyc, wb_stb, wb_we, wb_ack;
    logic [7:0] wb_adr, wb_dat_w;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   cyc_cnt = 0;
    int   t_start = 0;
    int   builds_done = 0;
    int   ack_delay = 0;
    bit   noise_en = 1'b0;
    bit   noise_bit = 1'b0;
    int   wait_cnt = 0;
    logic [7:0]  safe_cell = 8'd0;
    logic [15:0] m_lfsr, lfsr_prev;

    mine_placer #(
        .BOARD_SIZE(BS),
        .ADDR_W(8),
        .DATA_W(8),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mine_count(mine_count),
        .safe_x(safe_x),
        .safe_y(safe_y),
        .busy(busy),
        .done(done),
        .wb_cyc(wb_cyc),
        .wb_stb(wb_stb),
        .wb_we(wb_we),
        .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w),
        .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave: ack after ack_delay extra cycles of stb; random junk acks while idle.
    assign wb_ack = wb_stb ? (wait_cnt == ack_delay) : (noise_en && noise_bit);
    always @(posedge clk) begin
        if (wb_stb && !wb_ack) wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
        noise_bit <= 1'($urandom);
    end

    // Reference LFSR: 16-bit Galois, mask B400, one step per clock.
    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr    <= SEED;
            lfsr_prev <= SEED;
        end else begin
            lfsr_prev <= m_lfsr;
            m_lfsr    <= ref_step(m_lfsr);
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    // Monitor: pops the scoreboard on each new write and on each done pulse.
    initial begin : monitor
        logic       prev_stb, prev_ack, prev_done;
        logic [7:0] prev_adr, prev_dat;
        logic [NCELL-1:0] placed_set;
        int   gap, mines_seen;
        exp_t e;
        prev_stb = 1'b0; prev_ack = 1'b0; prev_done = 1'b0;
        prev_adr = '0; prev_dat = '0; placed_set = '0;
        gap = 0; mines_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                prev_stb = 1'b0; prev_ack = 1'b0; prev_done = 1'b0; gap = 0;
            end else begin
                if (prev_stb && prev_ack) begin
                    chk("stb_drop_after_ack", wb_stb, 0);
                end else if (prev_stb && wb_stb) begin
                    chk("hold_adr", wb_adr, prev_adr);
                    chk("hold_dat", wb_dat_w, prev_dat);
                    chk("hold_cyc_we", {wb_cyc, wb_we}, 2'b11);
                end
                if (wb_stb && !prev_stb) begin
                    chk("new_cyc_we", {wb_cyc, wb_we}, 2'b11);
                    chk("busy_during_write", busy, 1);
                    chk("write_was_expected", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("write_not_done_slot", (e.kind != K_DONE) ? 1 : 0, 1);
                        if (e.kind == K_CLR) begin
                            chk("clear_adr", wb_adr, e.adr);
                            chk("clear_dat", wb_dat_w, 0);
                            if (e.adr == 0) begin
                                placed_set = '0;
                                mines_seen = 0;
                            end else begin
                                chk("clear_gap", gap, 1);
                            end
                        end else if (e.kind == K_MINE) begin
                            chk("mine_dat", wb_dat_w, 1);
                            chk("mine_adr_from_lfsr", wb_adr, lfsr_prev[7:0]);
                            chk("mine_not_safe", (wb_adr == safe_cell) ? 1 : 0, 0);
                            chk("mine_distinct", placed_set[wb_adr], 0);
                            placed_set[wb_adr] = 1'b1;
                            mines_seen++;
                        end
                    end
                    gap = 0;
                end
                if (!wb_stb) gap++;
                if (done) begin
                    chk("done_one_cycle", prev_done, 0);
                    if (!prev_done) begin
                        chk("done_was_expected",
                            (sb.size() > 0 && sb[0].kind == K_DONE) ? 1 : 0, 1);
                        if (sb.size() > 0 && sb[0].kind == K_DONE) begin
                            e = sb.pop_front();
                            chk("busy_low_at_done", busy, 0);
                            chk("mine_total", mines_seen, e.cnt);
                            if (e.lat >= 0) chk("done_latency", cyc_cnt - t_start, e.lat);
                            if (e.cnt == NCELL - 1) begin
                                chk("full_cover_count", $countones(placed_set), NCELL - 1);
                                chk("full_cover_safe_empty", placed_set[safe_cell], 0);
                            end
                            builds_done++;
                        end
                    end
                end
                prev_stb  = wb_stb;
                prev_ack  = wb_ack;
                prev_adr  = wb_adr;
                prev_dat  = wb_dat_w;
                prev_done = done;
            end
        end
    end

    // Queue the whole expected transaction list, then pulse start.
    task automatic build(input int cnt, input int x, input int y, input int lat);
        int exp_m;
        exp_m = (cnt > NCELL - 1) ? NCELL - 1 : cnt;
        @(negedge clk); #1;
        for (int i = 0; i < NCELL; i++) sb.push_back('{K_CLR, i, 0, -1});
        for (int i = 0; i < exp_m; i++) sb.push_back('{K_MINE, 0, 0, -1});
        sb.push_back('{K_DONE, 0, exp_m, lat});
        safe_cell  = 8'((y * BS) + x);
        mine_count = 8'(cnt);
        safe_x     = 4'(x);
        safe_y     = 4'(y);
        start      = 1'b1;
        @(negedge clk); #1;
        start   = 1'b0;
        t_start = cyc_cnt;
    endtask

    task automatic wait_build(input int target);
        int n;
        n = 0;
        while (builds_done < target && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("build_completed", (builds_done >= target) ? 1 : 0, 1);
        if (builds_done < target) report();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int nb;
        int found;
        nb = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Idle after reset: every output at its reset value.
        repeat (20) begin
            @(negedge clk); #2;
            chk("idle_outputs", {busy, done, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w}, 0);
        end

        // Clear only.
        build(0, 0, 0, 2 * NCELL);
        nb++; wait_build(nb);

        // Ten mines, safe cell 0x53.
        build(10, 3, 5, -1);
        nb++; wait_build(nb);

        // Every cell but the safe corner.
        build(255, 0, 0, -1);
        nb++; wait_build(nb);

        // Slow slave with junk acks, plus start pulses while busy.
        ack_delay = 3;
        noise_en  = 1'b1;
        build(4, 1, 2, -1);
        repeat (5) begin
            repeat ($urandom_range(50, 200)) @(negedge clk);
            #1;
            if (busy) begin
                mine_count = 8'd7;
                safe_x     = 4'(9);
                start      = 1'b1;
                @(negedge clk); #1;
                start = 1'b0;
            end
        end
        nb++; wait_build(nb);
        ack_delay = 0;
        noise_en  = 1'b0;

        // Reset in the middle of the clear, then a full rebuild.
        build(3, 7, 9, -1);
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (wb_stb && wb_adr == 8'h40) found = 1;
        end
        chk("reached_adr_40", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_drops_cyc_stb", {wb_cyc, wb_stb}, 0);
        chk("rst_clears_busy", busy, 0);
        @(negedge clk); #1 rst = 1'b1;
        build(6, 15, 15, -1);
        nb++; wait_build(nb);

        // Randomized builds.
        repeat (3) begin
            ack_delay = $urandom_range(0, 2);
            build($urandom_range(1, 40), $urandom_range(0, BS - 1), $urandom_range(0, BS - 1), -1);
            nb++; wait_build(nb);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        report();
    end
endmodule
